fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 188 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one-outstanding memory handshake feeding a 2-deep {pc, instr} FIFO.
// Optional bubble counter enabled by defining FETCH_BUBBLE_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        jmp_taken,
    input  logic [31:0] jmp_target,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic [31:0] bubble_cnt
);

    typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_instr_d [2];
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        instr_valid_q, instr_valid_d;
    logic        push;
    logic        pop;
    logic [31:0] jmp_pc;
    logic        unused_jmp_low_bits;

    assign jmp_pc              = {jmp_target[31:2], 2'b00};
    assign unused_jmp_low_bits = ^jmp_target[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        imem_req   = 1'b0;
        push       = 1'b0;
        case (state_q)
            FETCH: begin
                if (jmp_taken) begin
                    pc_d = jmp_pc;
                end else if (count_q < 2'd2) begin
                    req_addr_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                imem_req = 1'b1;
                if (jmp_taken) begin
                    pc_d    = jmp_pc;
                    state_d = imem_ack ? FETCH : DROP;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    state_d = FETCH;
                end
            end
            DROP: begin
                // The abandoned request must still complete; its data is thrown away.
                imem_req = 1'b1;
                if (jmp_taken) begin
                    pc_d = jmp_pc;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_addr = req_addr_q;
    assign pop       = !jmp_taken && !stall && (count_q != 2'd0);

    always_comb begin
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;
        if (push) begin
            fifo_pc_d[wr_ptr_q]    = req_addr_q;
            fifo_instr_d[wr_ptr_q] = imem_rdata;
        end
        if (jmp_taken) begin
            count_d       = 2'd0;
            wr_ptr_d      = 1'b0;
            rd_ptr_d      = 1'b0;
            instr_d       = NOP_INSTR;
            instr_valid_d = 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d      = ~rd_ptr_q;
                instr_d       = fifo_instr_q[rd_ptr_q];
                pc_out_d      = fifo_pc_q[rd_ptr_q];
                instr_valid_d = 1'b1;
            end else if (!stall) begin
                // Nothing fetched yet: emit a bubble and keep the last PC visible.
                instr_d       = NOP_INSTR;
                instr_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            req_addr_q    <= 32'd0;
            count_q       <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            instr_q       <= NOP_INSTR;
            pc_out_q      <= 32'd0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_pc_q    <= fifo_pc_d;
        fifo_instr_q <= fifo_instr_d;
    end

    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = instr_valid_q;

`ifdef FETCH_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic        bubble_load;

    assign bubble_load = jmp_taken || (!stall && (count_q == 2'd0));

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= 32'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: streaming, wait states, stall, and redirects.
module tb_fetch_stage;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        stall;
    logic        jmp_taken;
    logic [31:0] jmp_target;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic [31:0] bubble_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    bit auto_ack = 1'b0;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .stall      (stall),
        .jmp_taken  (jmp_taken),
        .jmp_target (jmp_target),
        .instr      (instr),
        .pc_out     (pc_out),
        .instr_valid(instr_valid),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        if (auto_ack) begin
            imem_ack   = imem_req;
            imem_rdata = imem_addr ^ K;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        auto_ack   = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        stall      = 1'b0;
        jmp_taken  = 1'b0;
        jmp_target = 32'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        auto_ack   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        stall      = 1'b0;
        jmp_taken  = 1'b1;
        jmp_target = 32'h0000_0080;
        step();
        step();
        n_cmp++;
        if ({imem_req, instr_valid, instr, pc_out, bubble_cnt} !== {1'b0, 1'b0, NOP, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_state: got req=%b v=%b instr=%h pc=%h bub=%h expected 0 0 %h 0 0",
                     imem_req, instr_valid, instr, pc_out, bubble_cnt, NOP);
        end
        rst       = 1'b0;
        imem_ack  = 1'b0;
        jmp_taken = 1'b0;
        step();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_first_req: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] last_pc;
        logic [31:0] exp_instr;
        logic        exp_v;
        apply_reset();
        auto_ack = 1'b1;
        last_pc  = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_v = (k >= 3) && (k % 2 == 1);
            if (exp_v) last_pc = 32'((k - 3) / 2 * 4);
            exp_instr = exp_v ? (last_pc ^ K) : NOP;
            n_cmp++;
            if ({instr_valid, instr, pc_out} !== {exp_v, exp_instr, last_pc}) begin
                n_bad++;
                $display("FAIL stream_c%0d: got v=%b instr=%h pc=%h expected v=%b instr=%h pc=%h",
                         k, instr_valid, instr, pc_out, exp_v, exp_instr, last_pc);
            end
        end
        auto_ack = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic test_ack_wait();
        apply_reset();
        step();
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if ({imem_req, imem_addr, instr_valid, instr} !== {1'b1, 32'd0, 1'b0, NOP}) begin
                n_bad++;
                $display("FAIL wait_hold_c%0d: got req=%b addr=%h v=%b instr=%h expected 1 00000000 0 %h",
                         k, imem_req, imem_addr, instr_valid, instr, NOP);
            end
            if (k < 5) step();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hA5A5_0000;
        step();
        n_cmp++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL wait_ack: got req=%b v=%b expected 0 0", imem_req, instr_valid);
        end
        imem_ack = 1'b0;
        step();
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid, instr, pc_out} !== {1'b1, 32'd4, 1'b1, 32'hA5A5_0000, 32'd0}) begin
            n_bad++;
            $display("FAIL wait_out: got req=%b addr=%h v=%b instr=%h pc=%h expected 1 00000004 1 a5a50000 00000000",
                     imem_req, imem_addr, instr_valid, instr, pc_out);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rel_pc [4]  = '{32'd0, 32'd4, 32'd4, 32'd8};
        logic        rel_v  [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_instr;
        apply_reset();
        auto_ack = 1'b1;
        stall    = 1'b1;
        for (int k = 0; k < 4; k++) step();
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++;
            if ({imem_req, instr_valid, instr, pc_out} !== {1'b0, 1'b0, NOP, 32'd0}) begin
                n_bad++;
                $display("FAIL stall_full_c%0d: got req=%b v=%b instr=%h pc=%h expected 0 0 %h 0",
                         k, imem_req, instr_valid, instr, pc_out, NOP);
            end
        end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            exp_instr = rel_v[k] ? (rel_pc[k] ^ K) : NOP;
            n_cmp++;
            if ({instr_valid, instr, pc_out} !== {rel_v[k], exp_instr, rel_pc[k]}) begin
                n_bad++;
                $display("FAIL stall_release_c%0d: got v=%b instr=%h pc=%h expected v=%b instr=%h pc=%h",
                         k, instr_valid, instr, pc_out, rel_v[k], exp_instr, rel_pc[k]);
            end
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if ({instr_valid, instr, pc_out} !== {1'b1, 32'd8 ^ K, 32'd8}) begin
                n_bad++;
                $display("FAIL stall_hold_c%0d: got v=%b instr=%h pc=%h expected 1 %h 00000008",
                         k, instr_valid, instr, pc_out, 32'd8 ^ K);
            end
        end
        stall = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if ({instr_valid, instr, pc_out} !== {1'b1, (32'd12 + 32'(4 * k)) ^ K, 32'd12 + 32'(4 * k)}) begin
                n_bad++;
                $display("FAIL stall_resume_c%0d: got v=%b instr=%h pc=%h expected pc=%h",
                         k, instr_valid, instr, pc_out, 32'd12 + 32'(4 * k));
            end
        end
        auto_ack = 1'b0;
        imem_ack = 1'b0;
    endtask

    task automatic test_jump_drop();
        logic [31:0] exp_bub;
        apply_reset();
        step();
        jmp_taken  = 1'b1;
        jmp_target = 32'h0000_0103;
        step();
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid, instr} !== {1'b1, 32'd0, 1'b0, NOP}) begin
            n_bad++;
            $display("FAIL jump_drop_enter: got req=%b addr=%h v=%b instr=%h expected 1 00000000 0 %h",
                     imem_req, imem_addr, instr_valid, instr, NOP);
        end
        jmp_taken  = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        n_cmp++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL jump_drop_ack: got req=%b v=%b expected 0 0", imem_req, instr_valid);
        end
        imem_ack = 1'b0;
        step();
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0000_0100, 1'b0}) begin
            n_bad++;
            $display("FAIL jump_new_addr: got req=%b addr=%h v=%b expected 1 00000100 0",
                     imem_req, imem_addr, instr_valid);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0100 ^ K;
        step();
        imem_ack = 1'b0;
        step();
        n_cmp++;
        if ({instr_valid, instr, pc_out} !== {1'b1, 32'h0000_0100 ^ K, 32'h0000_0100}) begin
            n_bad++;
            $display("FAIL jump_first_instr: got v=%b instr=%h pc=%h expected 1 %h 00000100",
                     instr_valid, instr, pc_out, 32'h0000_0100 ^ K);
        end
`ifdef FETCH_BUBBLE_CNT_EN
        exp_bub = 32'd5;
`else
        exp_bub = 32'd0;
`endif
        n_cmp++;
        if (bubble_cnt !== exp_bub) begin
            n_bad++;
            $display("FAIL jump_bubble_cnt: got %0d expected %0d", bubble_cnt, exp_bub);
        end
    endtask

    task automatic test_jump_in_drop();
        apply_reset();
        step();
        jmp_taken  = 1'b1;
        jmp_target = 32'h0000_0103;
        step();
        jmp_target = 32'h0000_02FE;
        step();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL drop_rejump: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
        jmp_taken = 1'b0;
        imem_ack  = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_02FC}) begin
            n_bad++;
            $display("FAIL drop_rejump_addr: got req=%b addr=%h expected 1 000002fc", imem_req, imem_addr);
        end
    endtask

    task automatic test_jump_ack_stall();
        apply_reset();
        auto_ack = 1'b1;
        stall    = 1'b1;
        for (int k = 0; k < 3; k++) step();
        auto_ack   = 1'b0;
        jmp_taken  = 1'b1;
        jmp_target = 32'h0000_0040;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_1234;
        step();
        n_cmp++;
        if ({imem_req, instr_valid, instr} !== {1'b0, 1'b0, NOP}) begin
            n_bad++;
            $display("FAIL jack_flush: got req=%b v=%b instr=%h expected 0 0 %h",
                     imem_req, instr_valid, instr, NOP);
        end
        jmp_taken = 1'b0;
        imem_ack  = 1'b0;
        stall     = 1'b0;
        step();
        n_cmp++;
        if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0000_0040, 1'b0}) begin
            n_bad++;
            $display("FAIL jack_refetch: got req=%b addr=%h v=%b expected 1 00000040 0",
                     imem_req, imem_addr, instr_valid);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0040 ^ K;
        step();
        imem_ack = 1'b0;
        step();
        n_cmp++;
        if ({instr_valid, instr, pc_out} !== {1'b1, 32'h0000_0040 ^ K, 32'h0000_0040}) begin
            n_bad++;
            $display("FAIL jack_first_instr: got v=%b instr=%h pc=%h expected 1 %h 00000040",
                     instr_valid, instr, pc_out, 32'h0000_0040 ^ K);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ack_wait();
        test_stall();
        test_jump_drop();
        test_jump_in_drop();
        test_jump_ack_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
